// File: rtl/proj_input_loader.sv
// Serial-to-parallel loader: shifts in {sel, data[, parity]} frames and latches data into per-project holding registers.
// Optional feature: define LOADER_PARITY_EN to append and check a trailing even-parity bit.
module proj_input_loader #(
    parameter int BITS  = 16,
    parameter int NPROJ = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sdi,
    input  logic                   sdv,
    input  logic                   sfs,
    output logic [NPROJ*BITS-1:0]  proj_in,
    output logic [NPROJ-1:0]       wr_strobe,
    output logic                   ready,
    output logic                   busy,
    output logic                   err
);

`ifdef LOADER_PARITY_EN
    localparam int FLEN = BITS + 5;
`else
    localparam int FLEN = BITS + 4;
`endif
    localparam int CW = $clog2(FLEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FLEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state, next_state;
    logic [FLEN-1:0] shreg;
    logic [CW-1:0]   count;
    logic            start;
    logic            shift_in;
    logic [3:0]      sel;
    logic [BITS-1:0] data;
    logic            frame_ok;

    // The frame is fully aligned in the shift register once FLEN bits have arrived.
    assign sel = shreg[FLEN-1 -: 4];
`ifdef LOADER_PARITY_EN
    assign data     = shreg[BITS:1];
    assign frame_ok = (int'(sel) < NPROJ) && !(^shreg);
`else
    assign data     = shreg[BITS-1:0];
    assign frame_ok = (int'(sel) < NPROJ);
`endif

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        shift_in   = 1'b0;
        case (state)
            IDLE: begin
                if (sdv && sfs) begin
                    start      = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (sdv && sfs) begin
                    start = 1'b1;
                end else if (sdv) begin
                    shift_in = 1'b1;
                    if (count == LAST_CNT) next_state = COMMIT;
                end
            end
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: the holding registers are reset because projects must see defined inputs after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            count     <= '0;
            proj_in   <= '0;
            wr_strobe <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            wr_strobe <= '0;
            busy      <= (next_state != IDLE);
            ready     <= (next_state != COMMIT);

            if (start) begin
                shreg <= {{(FLEN-1){1'b0}}, sdi};
                count <= CW'(1);
                if (state == IDLE) err <= 1'b0;
            end else if (shift_in) begin
                shreg <= {shreg[FLEN-2:0], sdi};
                count <= count + CW'(1);
            end

            if (state == COMMIT) begin
                count <= '0;
                if (frame_ok) begin
                    for (int k = 0; k < NPROJ; k++) begin
                        if (int'(sel) == k) begin
                            proj_in[k*BITS +: BITS] <= data;
                            wr_strobe[k]            <= 1'b1;
                        end
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_proj_input_loader.sv
// Self-checking bench for proj_input_loader: table-driven frames plus restart, gapped, reset-abort and back-to-back sequences.
// Define LOADER_PARITY_EN for both files to exercise the parity build.
module tb_proj_input_loader;

    localparam int BITS  = 16;
    localparam int NPROJ = 11;
`ifdef LOADER_PARITY_EN
    localparam int FLEN = BITS + 5;
`else
    localparam int FLEN = BITS + 4;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  sdi = 1'b0;
    logic                  sdv = 1'b0;
    logic                  sfs = 1'b0;
    logic [NPROJ*BITS-1:0] proj_in;
    logic [NPROJ-1:0]      wr_strobe;
    logic                  ready;
    logic                  busy;
    logic                  err;

    int checks = 0;
    int errors = 0;

    logic [NPROJ*BITS-1:0] exp_proj = '0;

    proj_input_loader #(.BITS(BITS), .NPROJ(NPROJ)) dut (
        .clk       (clk),
        .rst       (rst),
        .sdi       (sdi),
        .sdv       (sdv),
        .sfs       (sfs),
        .proj_in   (proj_in),
        .wr_strobe (wr_strobe),
        .ready     (ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]       sel;
        logic [15:0]      data;
        int               gap;
        logic [NPROJ-1:0] exp_strobe;
        logic             exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [NPROJ*BITS-1:0] act,
                         input logic [NPROJ*BITS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FLEN-1:0] mk_frame(input logic [3:0] s, input logic [15:0] d,
                                                 input logic flip);
        logic [FLEN-1:0] f;
`ifdef LOADER_PARITY_EN
        f = {s, d, ^{s, d}};
`else
        f = {s, d};
`endif
        if (flip) f[0] = ~f[0];
        return f;
    endfunction

    // Caller is at a negedge; first bit is accepted at the next posedge.
    task automatic send_bits(input logic [3:0] s, input logic [15:0] d, input int n);
        logic [FLEN-1:0] f;
        f = mk_frame(s, d, 1'b0);
        for (int i = 0; i < n; i++) begin
            sdv = 1'b1;
            sfs = (i == 0);
            sdi = f[FLEN-1-i];
            @(negedge clk);
        end
        sdv = 1'b0;
        sfs = 1'b0;
    endtask

    // Returns at the negedge after the COMMIT cycle, where proj_in/wr_strobe/err are visible.
    task automatic send_frame(input logic [3:0] s, input logic [15:0] d, input int gap,
                              input logic flip, input logic poke, output logic err_at_start);
        logic [FLEN-1:0] f;
        f = mk_frame(s, d, flip);
        err_at_start = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            sdv = 1'b1;
            sfs = (i == 0);
            sdi = f[FLEN-1-i];
            @(negedge clk);
            if (i == 0) err_at_start = err;
            if (gap > 0 && i < FLEN - 1) begin
                sdv = 1'b0;
                sfs = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        sdv = poke;
        sfs = poke;
        sdi = poke;
        check("commit_ready", {{(NPROJ*BITS-1){1'b0}}, ready}, '0);
        check("commit_busy", {{(NPROJ*BITS-1){1'b0}}, busy}, 1);
        check("commit_no_early_strobe", {{(NPROJ*BITS-NPROJ){1'b0}}, wr_strobe}, '0);
        @(negedge clk);
        sdv = 1'b0;
        sfs = 1'b0;
        sdi = 1'b0;
        check("post_commit_busy", {{(NPROJ*BITS-1){1'b0}}, busy}, '0);
        check("post_commit_ready", {{(NPROJ*BITS-1){1'b0}}, ready}, 1);
    endtask

    task automatic check_outputs(input string tag, input logic [NPROJ-1:0] exp_strobe,
                                 input logic exp_err);
        check({tag, "_proj_in"}, proj_in, exp_proj);
        check({tag, "_strobe"}, {{(NPROJ*BITS-NPROJ){1'b0}}, wr_strobe},
              {{(NPROJ*BITS-NPROJ){1'b0}}, exp_strobe});
        check({tag, "_err"}, {{(NPROJ*BITS-1){1'b0}}, err}, {{(NPROJ*BITS-1){1'b0}}, exp_err});
    endtask

    task automatic apply_model(input logic [NPROJ-1:0] strobe, input logic [15:0] d);
        for (int k = 0; k < NPROJ; k++)
            if (strobe[k]) exp_proj[k*BITS +: BITS] = d;
    endtask

    initial begin
        logic e0;

        vecs[0] = '{4'h3, 16'hA5C3, 0, 11'h008, 1'b0};
        vecs[1] = '{4'hC, 16'hFFFF, 0, 11'h000, 1'b1};
        vecs[2] = '{4'h0, 16'h0001, 0, 11'h001, 1'b0};
        vecs[3] = '{4'hA, 16'hBEEF, 1, 11'h400, 1'b0};
        vecs[4] = '{4'hB, 16'h1234, 0, 11'h000, 1'b1};
        vecs[5] = '{4'hA, 16'hBEEF, 0, 11'h400, 1'b0};
        vecs[6] = '{4'hF, 16'h0000, 0, 11'h000, 1'b1};
        vecs[7] = '{4'h3, 16'h0000, 0, 11'h008, 1'b0};

        repeat (3) @(negedge clk);
        check_outputs("reset", '0, 1'b0);
        check("reset_busy", {{(NPROJ*BITS-1){1'b0}}, busy}, '0);
        check("reset_ready", {{(NPROJ*BITS-1){1'b0}}, ready}, 1);
        rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].sel, vecs[v].data, vecs[v].gap, 1'b0, 1'b0, e0);
            check($sformatf("v%0d_err_cleared_at_sfs", v), {{(NPROJ*BITS-1){1'b0}}, e0}, '0);
            apply_model(vecs[v].exp_strobe, vecs[v].data);
            check_outputs($sformatf("v%0d", v), vecs[v].exp_strobe, vecs[v].exp_err);
            @(negedge clk);
            check($sformatf("v%0d_strobe_drop", v), {{(NPROJ*BITS-NPROJ){1'b0}}, wr_strobe}, '0);
            check($sformatf("v%0d_proj_hold", v), proj_in, exp_proj);
        end

        // sdv without sfs in IDLE must not start a frame.
        sdv = 1'b1;
        sdi = 1'b1;
        repeat (3) @(negedge clk);
        sdv = 1'b0;
        check("idle_ignore_busy", {{(NPROJ*BITS-1){1'b0}}, busy}, '0);

        // Restart: partial frame to sel 2 abandoned by a new sfs.
        send_bits(4'h2, 16'h5555, 9);
        check("partial_busy", {{(NPROJ*BITS-1){1'b0}}, busy}, 1);
        send_frame(4'h5, 16'h1234, 0, 1'b0, 1'b0, e0);
        apply_model(11'h020, 16'h1234);
        check_outputs("restart", 11'h020, 1'b0);
        @(negedge clk);

        // Gapped frame to sel 7, then a second frame aborted by reset after 15 bits.
        send_frame(4'h7, 16'h8001, 2, 1'b0, 1'b0, e0);
        apply_model(11'h080, 16'h8001);
        check_outputs("gapped", 11'h080, 1'b0);
        @(negedge clk);
        send_bits(4'h7, 16'h4321, 15);
        check_outputs("aborted_pre_reset", 11'h000, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        exp_proj = '0;
        check_outputs("mid_frame_reset", 11'h000, 1'b0);
        check("mid_frame_reset_busy", {{(NPROJ*BITS-1){1'b0}}, busy}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("after_reset_idle", 11'h000, 1'b0);

        // Back-to-back: second sfs at the earliest legal edge, with a bit poked during COMMIT.
        send_frame(4'h1, 16'h1111, 0, 1'b0, 1'b1, e0);
        apply_model(11'h002, 16'h1111);
        check_outputs("b2b_first", 11'h002, 1'b0);
        send_frame(4'hA, 16'hAAAA, 0, 1'b0, 1'b0, e0);
        apply_model(11'h400, 16'hAAAA);
        check_outputs("b2b_second", 11'h400, 1'b0);
        @(negedge clk);

`ifdef LOADER_PARITY_EN
        send_frame(4'h2, 16'h00FF, 0, 1'b0, 1'b0, e0);
        apply_model(11'h004, 16'h00FF);
        check_outputs("parity_ok", 11'h004, 1'b0);
        @(negedge clk);
        send_frame(4'h2, 16'h0F0F, 0, 1'b1, 1'b0, e0);
        check_outputs("parity_bad", 11'h000, 1'b1);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
